// File: rtl/pc_core_axi_mem_responder.sv
// Register-array AXI4 slave standing in for DRAM behind a pc_core kernel's
// dram0_axi port. Independent read/write FSMs, INCR bursts that wrap at the
// top of memory, one beat per cycle, sticky wlast error and beat counters.
module pc_core_axi_mem_responder #(
  parameter int C_S_AXI_ADDR_WIDTH = 64,
  parameter int C_S_AXI_DATA_WIDTH = 512,
  parameter int C_MEM_DEPTH_WORDS  = 1024
) (
  input  logic                            ap_clk,
  input  logic                            areset,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]                      s_axi_awlen,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wlast,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]                      s_axi_arlen,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic                            s_axi_rlast,
  output logic                            err_wlast,
  output logic [31:0]                     wr_beat_cnt,
  output logic [31:0]                     rd_beat_cnt
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int BPW = DW / 8;
  localparam int OFF = $clog2(BPW);
  localparam int IW  = $clog2(C_MEM_DEPTH_WORDS);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  logic [DW-1:0] mem [C_MEM_DEPTH_WORDS];

  wstate_t    w_state;
  idx_t       w_idx;
  logic [7:0] w_len, w_cnt;
  rstate_t    r_state;
  idx_t       r_idx;
  logic [7:0] r_len, r_cnt;

  // Byte offset bits are dropped and the index is taken modulo depth, so the
  // upper address bits are deliberately left unused.
  idx_t aw_idx, ar_idx;
  logic unused_addr;
  assign aw_idx      = s_axi_awaddr[OFF +: IW];
  assign ar_idx      = s_axi_araddr[OFF +: IW];
  assign unused_addr = ^{s_axi_awaddr, s_axi_araddr};

  logic w_fire, w_final, r_fire;
  assign w_fire  = s_axi_wvalid && s_axi_wready;
  assign w_final = (w_cnt == w_len);
  assign r_fire  = s_axi_rvalid && s_axi_rready;

  // Write FSM: accept AW, take awlen+1 beats (wlast only checked), then hold B.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      w_idx         <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      err_wlast     <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          s_axi_awready <= 1'b1;
          if (s_axi_awvalid && s_axi_awready) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_idx         <= aw_idx;
            w_len         <= s_axi_awlen;
            w_cnt         <= '0;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            // Burst length is governed by awlen; wlast is only audited.
            if (s_axi_wlast != w_final) err_wlast <= 1'b1;
            if (w_final) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Byte-lane commit of accepted W beats; storage is intentionally not reset.
  always_ff @(posedge ap_clk) begin
    if (w_fire) begin
      for (int b = 0; b < BPW; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // Read FSM: first word loads on the AR edge, later words on each handshake,
  // giving back-to-back beats; an edge-coincident write is not yet visible.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          s_axi_arready <= 1'b1;
          if (s_axi_arvalid && s_axi_arready) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rdata   <= mem[ar_idx];
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            r_idx         <= ar_idx + 1'b1;
            r_len         <= s_axi_arlen;
            r_cnt         <= '0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              s_axi_rdata <= mem[r_idx];
              r_idx       <= r_idx + 1'b1;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Accepted-beat counters, free-running and wrapping.
  always_ff @(posedge ap_clk or posedge areset) begin
    if (areset) begin
      wr_beat_cnt <= '0;
      rd_beat_cnt <= '0;
    end else begin
      if (w_fire) wr_beat_cnt <= wr_beat_cnt + 32'd1;
      if (r_fire) rd_beat_cnt <= rd_beat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_core_axi_mem_responder.sv
// Bench for pc_core_axi_mem_responder: directed scenarios plus randomized
// bursts, all checked against a word-array memory model and beat tallies.
module tb_pc_core_axi_mem_responder;

  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int DEPTH = 1024;
  localparam int BPW   = DW / 8;

  typedef logic [DW-1:0]  word_t;
  typedef logic [BPW-1:0] strb_t;
  typedef word_t wq_t[$];
  typedef strb_t sq_t[$];
  typedef bit    bq_t[$];

  logic ap_clk = 1'b0;
  logic areset;
  logic s_axi_awvalid, s_axi_awready;
  logic [AW-1:0] s_axi_awaddr;
  logic [7:0] s_axi_awlen;
  logic s_axi_wvalid, s_axi_wready;
  word_t s_axi_wdata;
  strb_t s_axi_wstrb;
  logic s_axi_wlast, s_axi_bvalid, s_axi_bready;
  logic s_axi_arvalid, s_axi_arready;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0] s_axi_arlen;
  logic s_axi_rvalid, s_axi_rready;
  word_t s_axi_rdata;
  logic s_axi_rlast, err_wlast;
  logic [31:0] wr_beat_cnt, rd_beat_cnt;

  int vectors = 0;
  int errors  = 0;
  word_t mdl [DEPTH];
  int exp_wr = 0;
  int exp_rd = 0;

  always #5 ap_clk = ~ap_clk;

  pc_core_axi_mem_responder dut (
    .ap_clk(ap_clk), .areset(areset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast),
    .err_wlast(err_wlast), .wr_beat_cnt(wr_beat_cnt), .rd_beat_cnt(rd_beat_cnt)
  );

  // Byte address for a word: random byte offset and random aliasing high bits,
  // both of which the responder must ignore.
  function automatic logic [AW-1:0] waddr(input int w);
    logic [AW-1:0] a;
    a = AW'(w) * AW'(BPW) + AW'($urandom_range(0, BPW-1));
    a = a + (AW'($urandom_range(0, 3)) * AW'(DEPTH) * AW'(BPW));
    return a;
  endfunction

  function automatic word_t rnd_word();
    word_t w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic void mdl_write(input int w, input word_t d, input strb_t s);
    for (int b = 0; b < BPW; b++)
      if (s[b]) mdl[w % DEPTH][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  function automatic bit rr(input int mode, input int t);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (t % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic aw_send(input int w, input logic [7:0] len);
    bit got = 0;
    int t = 0;
    s_axi_awaddr = waddr(w); s_axi_awlen = len; s_axi_awvalid = 1'b1;
    while (!got && t < 50) begin
      @(negedge ap_clk); got = s_axi_awready; @(posedge ap_clk); #1; t++;
    end
    s_axi_awvalid = 1'b0;
    if (!got) begin errors++; $display("FAIL aw_timeout: awready=0 want 1"); end
  endtask

  task automatic w_send(input wq_t d, input sq_t s, input int last_at, input bit gaps,
                        input int bdly, output int blat, output bit bheld);
    bit got;
    int t;
    blat = 0; bheld = 0;
    s_axi_bready = (bdly == 0);
    for (int k = 0; k < d.size(); k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        s_axi_wvalid = 1'b0; @(posedge ap_clk); #1;
      end
      s_axi_wvalid = 1'b1; s_axi_wdata = d[k]; s_axi_wstrb = s[k];
      s_axi_wlast = (k == last_at);
      got = 0; t = 0;
      while (!got && t < 50) begin
        @(negedge ap_clk); got = s_axi_wready; @(posedge ap_clk); #1; t++;
      end
      if (!got) begin
        errors++; $display("FAIL w_timeout: wready=0 want 1 at beat %0d", k);
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b1; return;
      end
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    got = 0;
    while (!got && blat < 50) begin
      @(negedge ap_clk); blat++; got = s_axi_bvalid;
      if (!got) begin @(posedge ap_clk); #1; end
    end
    if (!got) begin
      errors++; $display("FAIL b_timeout: bvalid=0 want 1");
      s_axi_bready = 1'b1; return;
    end
    if (bdly > 0) begin
      repeat (bdly) begin @(posedge ap_clk); #1; end
      s_axi_bready = 1'b1;
      @(negedge ap_clk); bheld = s_axi_bvalid;
    end else bheld = 1'b1;
    @(posedge ap_clk); #1;
    s_axi_bready = 1'b1;
  endtask

  task automatic ar_recv(input int w, input logic [7:0] len, input int mode, input int max_beats,
                         output wq_t data, output bq_t lasts, output int rlat, output int unstable);
    bit got = 0, held = 0, hl = 0;
    word_t hd = '0;
    int t = 0;
    data = {}; lasts = {}; rlat = 0; unstable = 0;
    s_axi_araddr = waddr(w); s_axi_arlen = len; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    while (!got && t < 50) begin
      @(negedge ap_clk); got = s_axi_arready; @(posedge ap_clk); #1; t++;
    end
    s_axi_arvalid = 1'b0;
    if (!got) begin errors++; $display("FAIL ar_timeout: arready=0 want 1"); return; end
    t = 0;
    s_axi_rready = rr(mode, 1);
    while (data.size() < max_beats && t < 400) begin
      @(negedge ap_clk); t++;
      if (rlat == 0 && s_axi_rvalid) rlat = t;
      if (s_axi_rvalid) begin
        if (held && (s_axi_rdata !== hd || s_axi_rlast !== hl)) unstable++;
        if (s_axi_rready) begin
          data.push_back(s_axi_rdata); lasts.push_back(s_axi_rlast); held = 0;
        end else begin
          held = 1; hd = s_axi_rdata; hl = s_axi_rlast;
        end
      end
      @(posedge ap_clk); #1;
      s_axi_rready = rr(mode, t + 1);
    end
    s_axi_rready = 1'b0;
    if (t >= 400) begin errors++; $display("FAIL r_timeout: beats=%0d want %0d", data.size(), max_beats); end
  endtask

  // Compare a received burst against the model, starting at word w.
  task automatic chk_burst(input string nm, input int w, input int len, input wq_t data,
                           input bq_t lasts, input int unstable);
    vectors++;
    if (data.size() !== len + 1) begin
      errors++; $display("FAIL %s_beats: got %0d want %0d", nm, data.size(), len + 1);
      return;
    end
    for (int k = 0; k <= len; k++) begin
      vectors++;
      if (data[k] !== mdl[(w + k) % DEPTH] || lasts[k] !== (k == len)) begin
        errors++;
        $display("FAIL %s_beat%0d: got %h last %0d want %h last %0d", nm, k, data[k], lasts[k],
                 mdl[(w + k) % DEPTH], (k == len));
      end
    end
    vectors++;
    if (unstable !== 0) begin errors++; $display("FAIL %s_stall: %0d changes want 0", nm, unstable); end
  endtask

  task automatic chk_cnt(input string nm);
    vectors++;
    if (wr_beat_cnt !== 32'(exp_wr) || rd_beat_cnt !== 32'(exp_rd)) begin
      errors++;
      $display("FAIL %s_cnt: got wr %0d rd %0d want wr %0d rd %0d", nm, wr_beat_cnt, rd_beat_cnt, exp_wr, exp_rd);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_axi_awvalid = 0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 0;
    s_axi_bready = 1; s_axi_arvalid = 0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_rready = 0;
    repeat (3) @(posedge ap_clk);
    #1;
    vectors++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast} !== 7'b0
        || s_axi_rdata !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {s_axi_awready, s_axi_wready, s_axi_bvalid,
               s_axi_arready, s_axi_rvalid, s_axi_rlast, err_wlast});
    end
    chk_cnt("reset");
    areset = 1'b0;
    @(posedge ap_clk); #1;
    vectors++;
    if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got %b want 11", {s_axi_awready, s_axi_arready});
    end
  endtask

  task automatic test_single();
    wq_t d, rd; sq_t s; bq_t l; int blat, rlat, un; bit bh;
    d.push_back({(DW/8){8'hA5}}); s.push_back('1);
    aw_send(1, 8'd0);
    w_send(d, s, 0, 0, 0, blat, bh);
    mdl_write(1, d[0], s[0]); exp_wr++;
    vectors++;
    if (blat !== 1) begin errors++; $display("FAIL single_blat: got %0d want 1", blat); end
    vectors++;
    if (s_axi_awready !== 1'b1) begin errors++; $display("FAIL single_awready: got %b want 1", s_axi_awready); end
    ar_recv(1, 8'd0, 0, 1, rd, l, rlat, un);
    exp_rd++;
    vectors++;
    if (rlat !== 1) begin errors++; $display("FAIL single_rlat: got %0d want 1", rlat); end
    chk_burst("single", 1, 0, rd, l, un);
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid_off: got %b want 0", s_axi_rvalid); end
    chk_cnt("single");
  endtask

  task automatic test_burst();
    wq_t d, rd; sq_t s; bq_t l; int blat, rlat, un; bit bh;
    for (int k = 0; k < 16; k++) begin d.push_back(word_t'(k)); s.push_back('1); end
    aw_send(0, 8'd15);
    w_send(d, s, 15, 0, 0, blat, bh);
    for (int k = 0; k < 16; k++) mdl_write(k, d[k], s[k]);
    exp_wr += 16;
    vectors++;
    if (blat !== 1) begin errors++; $display("FAIL burst_blat: got %0d want 1", blat); end
    ar_recv(0, 8'd15, 1, 16, rd, l, rlat, un);
    exp_rd += 16;
    chk_burst("burst", 0, 15, rd, l, un);
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin errors++; $display("FAIL burst_rvalid_off: got %b want 0", s_axi_rvalid); end
    chk_cnt("burst");
  endtask

  task automatic test_strobe();
    wq_t d, rd; sq_t s; bq_t l; int blat, rlat, un; bit bh;
    d.push_back('1); s.push_back('1);
    aw_send(5, 8'd0); w_send(d, s, 0, 0, 0, blat, bh);
    d[0] = '0; s[0] = strb_t'(1);
    aw_send(5, 8'd0); w_send(d, s, 0, 0, 0, blat, bh);
    mdl_write(5, '1, '1); mdl_write(5, '0, strb_t'(1)); exp_wr += 2;
    ar_recv(5, 8'd0, 0, 1, rd, l, rlat, un);
    exp_rd++;
    chk_burst("strobe", 5, 0, rd, l, un);
    vectors++;
    if (rd.size() != 1 || rd[0][7:0] !== 8'h00 || rd[0][DW-1:8] !== {(DW-8){1'b1}}) begin
      errors++; $display("FAIL strobe_bytes: got %h want ff..ff00", rd.size() ? rd[0] : '0);
    end
  endtask

  task automatic test_wrap();
    wq_t d, rd; sq_t s; bq_t l; int blat, rlat, un; bit bh;
    for (int k = 0; k < 4; k++) begin d.push_back(rnd_word()); s.push_back('1); end
    aw_send(DEPTH-2, 8'd3); w_send(d, s, 3, 0, 0, blat, bh);
    for (int k = 0; k < 4; k++) mdl_write(DEPTH-2+k, d[k], s[k]);
    exp_wr += 4;
    ar_recv(DEPTH-2, 8'd3, 0, 4, rd, l, rlat, un);
    exp_rd += 4;
    chk_burst("wrap", DEPTH-2, 3, rd, l, un);
    ar_recv(0, 8'd0, 0, 1, rd, l, rlat, un);
    exp_rd++;
    vectors++;
    if (rd.size() != 1 || rd[0] !== d[2]) begin
      errors++; $display("FAIL wrap_word0: got %h want %h", rd.size() ? rd[0] : '0, d[2]);
    end
  endtask

  task automatic test_protocol_err();
    wq_t d; sq_t s; int blat; bit bh;
    vectors++;
    if (err_wlast !== 1'b0) begin errors++; $display("FAIL perr_clean: got %b want 0", err_wlast); end
    for (int k = 0; k < 4; k++) begin d.push_back(rnd_word()); s.push_back('1); end
    aw_send(20, 8'd3); w_send(d, s, 1, 0, 0, blat, bh);
    for (int k = 0; k < 4; k++) mdl_write(20+k, d[k], s[k]);
    exp_wr += 4;
    vectors++;
    if (blat !== 1) begin errors++; $display("FAIL perr_blat: got %0d want 1", blat); end
    vectors++;
    if (err_wlast !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", err_wlast); end
    aw_send(20, 8'd3); w_send(d, s, 3, 0, 0, blat, bh);
    exp_wr += 4;
    vectors++;
    if (err_wlast !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", err_wlast); end
    chk_cnt("perr");
  endtask

  task automatic test_collision();
    word_t oldw, neww; wq_t rd; bq_t l; int rlat, un;
    oldw = mdl[7]; neww = rnd_word();
    aw_send(7, 8'd0);
    s_axi_wdata = neww; s_axi_wstrb = '1; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    s_axi_araddr = waddr(7); s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(negedge ap_clk);
    vectors++;
    if ({s_axi_wready, s_axi_arready} !== 2'b11) begin
      errors++; $display("FAIL coll_ready: got %b want 11", {s_axi_wready, s_axi_arready});
    end
    @(posedge ap_clk); #1;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge ap_clk);
    vectors++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== oldw) begin
      errors++; $display("FAIL coll_old: got v%b %h want v1 %h", s_axi_rvalid, s_axi_rdata, oldw);
    end
    vectors++;
    if (s_axi_bvalid !== 1'b1) begin errors++; $display("FAIL coll_bvalid: got %b want 1", s_axi_bvalid); end
    @(posedge ap_clk); #1;
    s_axi_rready = 1'b0;
    mdl_write(7, neww, '1); exp_wr++; exp_rd++;
    @(posedge ap_clk); #1;
    ar_recv(7, 8'd0, 0, 1, rd, l, rlat, un);
    exp_rd++;
    chk_burst("coll_new", 7, 0, rd, l, un);
    chk_cnt("coll");
  endtask

  task automatic test_random();
    wq_t d, rd; sq_t s; bq_t l; int blat, rlat, un, w, len, bd; bit bh;
    for (int k = 0; k < 64; k++) begin d.push_back(rnd_word()); s.push_back('1); end
    aw_send(0, 8'd63); w_send(d, s, 63, 0, 0, blat, bh);
    for (int k = 0; k < 64; k++) mdl_write(k, d[k], s[k]);
    exp_wr += 64;
    for (int it = 0; it < 30; it++) begin
      w = $urandom_range(0, 56); len = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin
        d = {}; s = {};
        for (int k = 0; k <= len; k++) begin
          d.push_back(rnd_word()); s.push_back({$urandom(), $urandom()});
        end
        bd = $urandom_range(0, 3);
        aw_send(w, 8'(len)); w_send(d, s, len, 1, bd, blat, bh);
        for (int k = 0; k <= len; k++) mdl_write(w+k, d[k], s[k]);
        exp_wr += len + 1;
        vectors++;
        if (blat !== 1 || bh !== 1'b1) begin
          errors++; $display("FAIL rand_b%0d: got lat %0d held %b want lat 1 held 1", it, blat, bh);
        end
      end else begin
        ar_recv(w, 8'(len), 2, len + 1, rd, l, rlat, un);
        exp_rd += len + 1;
        chk_burst("rand_rd", w, len, rd, l, un);
      end
    end
    chk_cnt("rand");
  endtask

  task automatic test_reset_mid();
    wq_t rd; bq_t l; int rlat, un;
    ar_recv(0, 8'd7, 0, 2, rd, l, rlat, un);
    areset = 1'b1;
    #1;
    vectors++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rdata !== '0 || err_wlast !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: got rvalid %b arready %b err %b want 0 0 0",
                         s_axi_rvalid, s_axi_arready, err_wlast);
    end
    exp_wr = 0; exp_rd = 0;
    chk_cnt("rstmid");
    repeat (2) @(posedge ap_clk);
    #1; areset = 1'b0;
    @(posedge ap_clk); #1;
    vectors++;
    if ({s_axi_arready, s_axi_awready, s_axi_rvalid} !== 3'b110) begin
      errors++; $display("FAIL rstmid_idle: got %b want 110", {s_axi_arready, s_axi_awready, s_axi_rvalid});
    end
    ar_recv(0, 8'd7, 0, 8, rd, l, rlat, un);
    exp_rd += 8;
    chk_burst("rstmid_keep", 0, 7, rd, l, un);
    chk_cnt("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_wrap();
    test_protocol_err();
    test_collision();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
